// File: rtl/display_pkg.sv
// Shared display timing constants, scheduler state encoding and the
// enabled-layer search helper used by the VRAM fetch scheduler.
package display_pkg;

  localparam int H_TOTAL     = 800;
  localparam int V_TOTAL     = 525;
  localparam int H_VIS_START = 144;
  localparam int V_VIS_START = 35;
  localparam int V_VIS_END   = 514;
  localparam int LAYER_IDX_W = 3;
  localparam int MAX_LAYERS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_CPU   = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic                   found;
    logic [LAYER_IDX_W-1:0] idx;
  } layer_pick_t;

  // Lowest enabled layer whose index is >= start; found=0 when none remain.
  function automatic layer_pick_t pick_layer(input logic [MAX_LAYERS-1:0] mask,
                                             input logic [LAYER_IDX_W:0]  start);
    layer_pick_t res;
    res.found = 1'b0;
    res.idx   = {LAYER_IDX_W{1'b0}};
    for (int i = MAX_LAYERS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(start))) begin
        res.found = 1'b1;
        res.idx   = LAYER_IDX_W'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vram_fetch_scheduler_fetch_trigger.sv
// fetch_trigger: detects the h_pos edge that opens a fetch window, works out
// which row of the next scanline to fetch, and flags the visible-start
// deadline. Outputs are combinational; the scheduler registers its actions.
module fetch_trigger
  import display_pkg::*;
#(
  parameter int FETCH_H_START = 784
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] h_pos,
  input  logic [9:0] v_pos,
  output logic       trigger,
  output logic       fetch_ok,
  output logic [8:0] row,
  output logic       deadline
);

  logic [9:0] h_prev_r;
  logic [9:0] next_line_s;

  // Remember last cycle's h_pos so a held value triggers only once.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_prev_r <= 10'd0;
    end else begin
      h_prev_r <= h_pos;
    end
  end

  // Edge detect, next-line wrap, row offset and deadline compare.
  always_comb begin
    trigger = (h_pos == 10'(FETCH_H_START)) && (h_prev_r != h_pos);
    if (v_pos == 10'(V_TOTAL - 1)) begin
      next_line_s = 10'd0;
    end else begin
      next_line_s = v_pos + 10'd1;
    end
    fetch_ok = (next_line_s >= 10'(V_VIS_START)) && (next_line_s <= 10'(V_VIS_END));
    row      = 9'(next_line_s - 10'(V_VIS_START));
    deadline = (h_pos == 10'(H_VIS_START));
  end

endmodule

// File: rtl/vram_fetch_scheduler.sv
// vram_fetch_scheduler: shares the single VRAM port between per-scanline
// line-buffer fetches and host CPU accesses, with a sticky underrun flag.
// Optional macro VRAM_CPU_INTERLEAVE_EN: serve a pending CPU access between
// fetch words; otherwise the CPU only gets the port outside fetch windows.
module vram_fetch_scheduler
  import display_pkg::*;
#(
  parameter int NUM_LAYERS    = 4,
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int ROW_SHIFT     = 3,
  parameter int FETCH_H_START = 784
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [9:0]                       h_pos,
  input  logic [9:0]                       v_pos,
  input  logic [NUM_LAYERS-1:0]            layer_en,
  input  logic [NUM_LAYERS*ADDR_WIDTH-1:0] layer_base,
  input  logic                             cpu_req,
  input  logic                             cpu_wr,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [DATA_WIDTH-1:0]            cpu_wdata,
  output logic                             cpu_ack,
  output logic [DATA_WIDTH-1:0]            cpu_rdata,
  output logic                             mem_req,
  output logic                             mem_wr,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic                             mem_ack,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic                             lb_we,
  output logic [2:0]                       lb_layer,
  output logic [ROW_SHIFT-1:0]             lb_addr,
  output logic [DATA_WIDTH-1:0]            lb_data,
  output logic                             fetch_busy,
  output logic                             underrun,
  input  logic                             underrun_clr
);

  sched_state_e state_r, state_s;
  logic [2:0]            layer_r, layer_s;
  logic [ROW_SHIFT-1:0]  word_r, word_s;
  logic [8:0]            row_r, row_s;
  logic [MAX_LAYERS-1:0] en_r, en_s;
  logic                  abort_r, abort_s;
  logic                  mem_req_r, mem_req_s, mem_wr_r, mem_wr_s;
  logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_r, mem_wdata_s;
  logic                  lb_we_r, lb_we_s;
  logic [2:0]            lb_layer_r, lb_layer_s;
  logic [ROW_SHIFT-1:0]  lb_addr_r, lb_addr_s;
  logic [DATA_WIDTH-1:0] lb_data_r, lb_data_s;
  logic                  cpu_ack_r, cpu_ack_s;
  logic [DATA_WIDTH-1:0] cpu_rdata_r, cpu_rdata_s;
  logic                  fetch_busy_r, fetch_busy_s;
  logic                  underrun_r, underrun_s;

  logic                  trig_s, fetch_ok_s, deadline_s;
  logic [8:0]            trig_row_s;
  logic [MAX_LAYERS-1:0] en_in_s;
  layer_pick_t           first_pick_s, next_pick_s;
  logic                  open_s, cpu_grant_ok_s, dl_hit_s, last_word_s;
  logic [2:0]            sel_layer_s;
  logic [8:0]            sel_row_s;
  logic [ROW_SHIFT-1:0]  sel_word_s;
  logic [ADDR_WIDTH-1:0] base_arr_s [MAX_LAYERS];
  logic [ADDR_WIDTH-1:0] fetch_addr_s;

  fetch_trigger #(.FETCH_H_START(FETCH_H_START)) u_trigger (
    .clk      (clk),
    .reset_n  (reset_n),
    .h_pos    (h_pos),
    .v_pos    (v_pos),
    .trigger  (trig_s),
    .fetch_ok (fetch_ok_s),
    .row      (trig_row_s),
    .deadline (deadline_s)
  );

  // Unpack base addresses; unused slots read as zero and are never enabled.
  for (genvar gi = 0; gi < MAX_LAYERS; gi++) begin : g_base
    if (gi < NUM_LAYERS) begin : g_used
      assign base_arr_s[gi] = layer_base[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end else begin : g_unused
      assign base_arr_s[gi] = {ADDR_WIDTH{1'b0}};
    end
  end

  assign en_in_s        = MAX_LAYERS'(layer_en);
  assign first_pick_s   = pick_layer(en_in_s, 4'd0);
  assign next_pick_s    = pick_layer(en_r, {1'b0, layer_r} + 4'd1);
  assign open_s         = trig_s && fetch_ok_s && first_pick_s.found;
  assign cpu_grant_ok_s = cpu_req && !cpu_ack_r;  // cpu_req is still high in the ack cycle
  assign dl_hit_s       = deadline_s && fetch_busy_r &&
                          ((state_r == ST_FETCH) || (state_r == ST_CPU));
  assign last_word_s    = &word_r;

  // Address source: window opening in IDLE uses the fresh trigger values.
  always_comb begin
    if (state_r == ST_IDLE) begin
      sel_layer_s = first_pick_s.idx;
      sel_row_s   = trig_row_s;
      sel_word_s  = {ROW_SHIFT{1'b0}};
    end else begin
      sel_layer_s = layer_r;
      sel_row_s   = row_r;
      sel_word_s  = word_r;
    end
    fetch_addr_s = base_arr_s[sel_layer_s]
                 + ADDR_WIDTH'({sel_row_s, {ROW_SHIFT{1'b0}}})
                 + ADDR_WIDTH'(sel_word_s);
  end

  // Next-state and next-output logic of the port arbiter.
  always_comb begin
    state_s      = state_r;
    layer_s      = layer_r;
    word_s       = word_r;
    row_s        = row_r;
    en_s         = en_r;
    abort_s      = abort_r || dl_hit_s;
    mem_req_s    = mem_req_r;
    mem_wr_s     = mem_wr_r;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;
    lb_we_s      = 1'b0;
    lb_layer_s   = lb_layer_r;
    lb_addr_s    = lb_addr_r;
    lb_data_s    = lb_data_r;
    cpu_ack_s    = 1'b0;
    cpu_rdata_s  = cpu_rdata_r;
    fetch_busy_s = fetch_busy_r;

    // A deadline hit always wins over a clear in the same cycle.
    if (dl_hit_s) begin
      underrun_s = 1'b1;
    end else if (underrun_clr) begin
      underrun_s = 1'b0;
    end else begin
      underrun_s = underrun_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (open_s) begin
          state_s      = ST_FETCH;
          layer_s      = first_pick_s.idx;
          word_s       = {ROW_SHIFT{1'b0}};
          row_s        = trig_row_s;
          en_s         = en_in_s;
          abort_s      = 1'b0;
          fetch_busy_s = 1'b1;
          mem_req_s    = 1'b1;
          mem_wr_s     = 1'b0;
          mem_addr_s   = fetch_addr_s;
        end else if (cpu_grant_ok_s) begin
          state_s     = ST_CPU;
          mem_req_s   = 1'b1;
          mem_wr_s    = cpu_wr;
          mem_addr_s  = cpu_addr;
          mem_wdata_s = cpu_wdata;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_FETCH: begin
        if (mem_req_r) begin
          if (mem_ack) begin
            mem_req_s  = 1'b0;
            lb_we_s    = 1'b1;
            lb_layer_s = layer_r;
            lb_addr_s  = word_r;
            lb_data_s  = mem_rdata;
            if (abort_r || dl_hit_s) begin
              state_s = ST_DONE;
            end else if (!last_word_s) begin
              word_s = word_r + ROW_SHIFT'(1'b1);
            end else if (next_pick_s.found) begin
              layer_s = next_pick_s.idx;
              word_s  = {ROW_SHIFT{1'b0}};
            end else begin
              state_s = ST_DONE;
            end
          end else begin
            mem_req_s = 1'b1;
          end
        end else begin
          if (abort_r || dl_hit_s) begin
            state_s = ST_DONE;
`ifdef VRAM_CPU_INTERLEAVE_EN
          end else if (cpu_grant_ok_s) begin
            state_s     = ST_CPU;
            mem_req_s   = 1'b1;
            mem_wr_s    = cpu_wr;
            mem_addr_s  = cpu_addr;
            mem_wdata_s = cpu_wdata;
`endif
          end else begin
            mem_req_s  = 1'b1;
            mem_wr_s   = 1'b0;
            mem_addr_s = fetch_addr_s;
          end
        end
      end

      ST_CPU: begin
        // A window that opens while the CPU owns the port starts after it.
        if (open_s && !fetch_busy_r) begin
          layer_s      = first_pick_s.idx;
          word_s       = {ROW_SHIFT{1'b0}};
          row_s        = trig_row_s;
          en_s         = en_in_s;
          abort_s      = 1'b0;
          fetch_busy_s = 1'b1;
        end else begin
          fetch_busy_s = fetch_busy_r;
        end
        if (mem_ack) begin
          mem_req_s   = 1'b0;
          mem_wr_s    = 1'b0;
          cpu_ack_s   = 1'b1;
          cpu_rdata_s = mem_rdata;
          if (fetch_busy_s) begin
            state_s = ST_FETCH;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          mem_req_s = 1'b1;
        end
      end

      ST_DONE: begin
        fetch_busy_s = 1'b0;
        abort_s      = 1'b0;
        state_s      = ST_IDLE;
      end

      default: begin
        state_s      = ST_IDLE;
        mem_req_s    = 1'b0;
        fetch_busy_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      layer_r      <= 3'd0;
      word_r       <= {ROW_SHIFT{1'b0}};
      row_r        <= 9'd0;
      en_r         <= {MAX_LAYERS{1'b0}};
      abort_r      <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_wr_r     <= 1'b0;
      mem_addr_r   <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r  <= {DATA_WIDTH{1'b0}};
      lb_we_r      <= 1'b0;
      lb_layer_r   <= 3'd0;
      lb_addr_r    <= {ROW_SHIFT{1'b0}};
      lb_data_r    <= {DATA_WIDTH{1'b0}};
      cpu_ack_r    <= 1'b0;
      cpu_rdata_r  <= {DATA_WIDTH{1'b0}};
      fetch_busy_r <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      layer_r      <= layer_s;
      word_r       <= word_s;
      row_r        <= row_s;
      en_r         <= en_s;
      abort_r      <= abort_s;
      mem_req_r    <= mem_req_s;
      mem_wr_r     <= mem_wr_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      lb_we_r      <= lb_we_s;
      lb_layer_r   <= lb_layer_s;
      lb_addr_r    <= lb_addr_s;
      lb_data_r    <= lb_data_s;
      cpu_ack_r    <= cpu_ack_s;
      cpu_rdata_r  <= cpu_rdata_s;
      fetch_busy_r <= fetch_busy_s;
      underrun_r   <= underrun_s;
    end
  end

  assign mem_req    = mem_req_r;
  assign mem_wr     = mem_wr_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign lb_we      = lb_we_r;
  assign lb_layer   = lb_layer_r;
  assign lb_addr    = lb_addr_r;
  assign lb_data    = lb_data_r;
  assign cpu_ack    = cpu_ack_r;
  assign cpu_rdata  = cpu_rdata_r;
  assign fetch_busy = fetch_busy_r;
  assign underrun   = underrun_r;

endmodule

// File: tb/tb_vram_fetch_scheduler.sv
// Directed bench for vram_fetch_scheduler: a table of fetch-window vectors
// plus hand-written CPU, underrun and reset sequences.
module tb_vram_fetch_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  h_pos, v_pos;
  logic [3:0]  layer_en;
  logic [63:0] layer_base;
  logic        cpu_req, cpu_wr;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        mem_req, mem_wr, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        lb_we;
  logic [2:0]  lb_layer, lb_addr;
  logic [15:0] lb_data;
  logic        fetch_busy, underrun, underrun_clr;
  logic        ack_en;

  always #5 clk = ~clk;

  assign mem_ack   = mem_req & ack_en;
  assign mem_rdata = mem_addr ^ 16'hA5C3;

  vram_fetch_scheduler dut (
    .clk(clk), .reset_n(reset_n), .h_pos(h_pos), .v_pos(v_pos),
    .layer_en(layer_en), .layer_base(layer_base),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .lb_we(lb_we), .lb_layer(lb_layer), .lb_addr(lb_addr), .lb_data(lb_data),
    .fetch_busy(fetch_busy), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  typedef struct {
    logic [2:0]  layer;
    logic [2:0]  word;
    logic [15:0] data;
    int          c;
  } lb_ev_t;

  typedef struct {
    logic [9:0] v;
    logic [3:0] en;
    int         words;
    logic [8:0] row;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc, busy_cnt, cpu_ack_cnt, ack_cyc;
  logic [15:0] last_rdata;
  logic [15:0] acc_addr_q[$];
  logic        acc_wr_q[$];
  logic [15:0] acc_wdata_q[$];
  int          acc_cyc_q[$];
  lb_ev_t      lb_q[$];
  vec_t        vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: log the access accepted at the coming edge, then sample.
  task automatic tick();
    if (mem_req && ack_en) begin
      acc_addr_q.push_back(mem_addr);
      acc_wr_q.push_back(mem_wr);
      acc_wdata_q.push_back(mem_wdata);
      acc_cyc_q.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
    if (fetch_busy) busy_cnt++;
    if (lb_we) lb_q.push_back('{lb_layer, lb_addr, lb_data, cyc});
    if (cpu_ack) begin
      cpu_ack_cnt++;
      ack_cyc    = cyc;
      last_rdata = cpu_rdata;
      cpu_req    = 1'b0;
    end
  endtask

  task automatic clear_mon();
    acc_addr_q.delete(); acc_wr_q.delete(); acc_wdata_q.delete(); acc_cyc_q.delete();
    lb_q.delete();
    cyc = 0; busy_cnt = 0; cpu_ack_cnt = 0; ack_cyc = 0;
  endtask

  task automatic run_trigger(input logic [9:0] v, input logic [3:0] en);
    v_pos    = v;
    layer_en = en;
    h_pos    = 10'd783;
    tick(); tick();
    clear_mon();
    h_pos = 10'd784;
  endtask

  initial begin
    int k, wr_idx, wr_n, lb_before;
    logic [15:0] ea;

    reset_n = 1'b0; h_pos = 10'd0; v_pos = 10'd0; layer_en = 4'h0;
    layer_base = {16'h3000, 16'h2000, 16'h1000, 16'h0000};
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    underrun_clr = 1'b0; ack_en = 1'b1;
    clear_mon();
    tick(); tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_lb_we", 32'(lb_we), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset_n = 1'b1;
    tick();

    // v_pos, layer_en, words fetched, row of next line
    vt[0] = '{10'd34,  4'b1111, 32, 9'd0};
    vt[1] = '{10'd514, 4'b1111, 0,  9'd0};
    vt[2] = '{10'd524, 4'b1111, 0,  9'd0};
    vt[3] = '{10'd513, 4'b0101, 16, 9'd479};
    vt[4] = '{10'd100, 4'b0000, 0,  9'd0};
    vt[5] = '{10'd200, 4'b1000, 8,  9'd166};

    for (int i = 0; i < 6; i++) begin
      run_trigger(vt[i].v, vt[i].en);
      repeat (150) tick();
      chk($sformatf("v%0d_lb_count", i), 32'(lb_q.size()), 32'(vt[i].words));
      chk($sformatf("v%0d_acc_count", i), 32'(acc_addr_q.size()), 32'(vt[i].words));
      chk($sformatf("v%0d_busy_cycles", i), 32'(busy_cnt), 32'(2 * vt[i].words));
      k = 0;
      for (int l = 0; l < 4; l++) begin
        if (vt[i].en[l]) begin
          for (int w = 0; w < 8; w++) begin
            ea = 16'(16'h1000 * l) + {4'h0, vt[i].row, 3'b000} + 16'(w);
            if (k < acc_addr_q.size())
              chk($sformatf("v%0d_addr%0d", i, k), 32'(acc_addr_q[k]), 32'(ea));
            if (k < lb_q.size()) begin
              chk($sformatf("v%0d_lbdata%0d", i, k), 32'(lb_q[k].data), 32'(ea ^ 16'hA5C3));
              chk($sformatf("v%0d_lbpos%0d", i, k), {26'd0, lb_q[k].layer, lb_q[k].word},
                  {26'd0, 3'(l), 3'(w)});
            end
            k++;
          end
        end
      end
      if (i == 0 && acc_addr_q.size() > 21 && lb_q.size() > 0) begin
        chk("l2w5_addr", 32'(acc_addr_q[21]), 32'h2005);
        chk("first_req_latency", 32'(acc_cyc_q[0]), 32'd1);
        chk("lb_we_latency", 32'(lb_q[0].c), 32'(acc_cyc_q[0] + 1));
      end
      h_pos = 10'd0;
      tick(); tick();
    end

    // CPU read while idle
    clear_mon();
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0123;
    for (int i = 0; i < 20 && cpu_ack_cnt == 0; i++) tick();
    repeat (5) tick();
    chk("cpu_rd_ack_count", 32'(cpu_ack_cnt), 32'd1);
    chk("cpu_rd_acc_count", 32'(acc_addr_q.size()), 32'd1);
    chk("cpu_rd_data", 32'(last_rdata), 32'hA4E0);
    if (acc_cyc_q.size() > 0)
      chk("cpu_rd_ack_latency", 32'(ack_cyc), 32'(acc_cyc_q[0] + 1));

    // CPU write arriving during a fetch window
    run_trigger(10'd34, 4'b1111);
    repeat (10) tick();
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'hBEEF;
    for (int i = 0; i < 200 && cpu_ack_cnt == 0; i++) tick();
    repeat (100) tick();
    cpu_wr = 1'b0;
    wr_n = 0; wr_idx = 0;
    for (int i = 0; i < acc_wr_q.size(); i++) begin
      if (acc_wr_q[i]) begin
        wr_n++;
        wr_idx = i;
      end
    end
    chk("cpu_wr_count", 32'(wr_n), 32'd1);
    chk("cpu_wr_ack_count", 32'(cpu_ack_cnt), 32'd1);
    chk("win_lb_count", 32'(lb_q.size()), 32'd32);
    if (wr_n > 0) begin
      chk("cpu_wr_addr", 32'(acc_addr_q[wr_idx]), 32'h0040);
      chk("cpu_wr_data", 32'(acc_wdata_q[wr_idx]), 32'hBEEF);
      chk("cpu_wr_ack_latency", 32'(ack_cyc), 32'(acc_cyc_q[wr_idx] + 1));
      lb_before = 0;
      foreach (lb_q[j]) if (lb_q[j].c <= acc_cyc_q[wr_idx]) lb_before++;
`ifdef VRAM_CPU_INTERLEAVE_EN
      chk("cpu_wr_interleaved", 32'(lb_before > 0 && lb_before < 32), 32'd1);
`else
      chk("cpu_wr_after_window", 32'(lb_before), 32'd32);
`endif
    end
    h_pos = 10'd0;
    tick(); tick();

    // Underrun: request stalls past the visible start of the line
    ack_en = 1'b0;
    run_trigger(10'd34, 4'b1111);
    repeat (10) tick();
    chk("stall_req_held", 32'(mem_req), 32'd1);
    chk("stall_addr_stable", 32'(mem_addr), 32'h0000);
    h_pos = 10'd144;
    tick(); tick();
    h_pos = 10'd145; ack_en = 1'b1;
    repeat (20) tick();
    chk("underrun_set", 32'(underrun), 32'd1);
    chk("abort_lb_count", 32'(lb_q.size()), 32'd1);
    chk("abort_acc_count", 32'(acc_addr_q.size()), 32'd1);
    chk("abort_busy_low", 32'(fetch_busy), 32'd0);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("underrun_cleared", 32'(underrun), 32'd0);
    tick();

    // Set and clear in the same cycles: set wins
    ack_en = 1'b0;
    run_trigger(10'd34, 4'b1111);
    repeat (4) tick();
    h_pos = 10'd144; underrun_clr = 1'b1;
    tick();
    chk("set_beats_clr", 32'(underrun), 32'd1);
    tick();
    h_pos = 10'd145; underrun_clr = 1'b0; ack_en = 1'b1;
    repeat (20) tick();
    chk("set_beats_clr_held", 32'(underrun), 32'd1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("underrun_cleared2", 32'(underrun), 32'd0);

    // Reset in the middle of a fetch
    ack_en = 1'b0;
    run_trigger(10'd34, 4'b1111);
    repeat (5) tick();
    chk("pre_reset_req", 32'(mem_req), 32'd1);
    chk("pre_reset_busy", 32'(fetch_busy), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_busy", 32'(fetch_busy), 32'd0);
    chk("midrst_lb_we", 32'(lb_we), 32'd0);
    chk("midrst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    reset_n = 1'b1; ack_en = 1'b1; h_pos = 10'd0;
    tick();
    run_trigger(10'd34, 4'b1111);
    repeat (100) tick();
    chk("post_reset_lb_count", 32'(lb_q.size()), 32'd32);
    chk("post_reset_busy_cycles", 32'(busy_cnt), 32'd64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
